snake_scoreboard_mux: RTL and testbench
=======================================

Name: snake_scoreboard_mux

Overview:
- Parametrised successor scoreboard driver: converts a binary score to BCD with a sequential double-dabble engine, then time-multiplexes NUM_DIGITS seven-segment digits.
- Sits between the game-logic score counter and the board's shared segment and digit-select pins.
- Adds the following:
  - True per-digit decimal conversion.
  - A refresh divider.
  - Score load handshake.
  - Overflow saturation.

Parameters:
- NUM_DIGITS, 4, number of displayed digits (1..8).
- SCORE_WIDTH, 14, binary score width.
- REFRESH_DIV, 50000, clock cycles each digit is held active (≥2).

Ports:
- i_Clk  in  1  system clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Score  in  SCORE_WIDTH  unsigned score to display.
- i_ScoreValid  in  1  one-cycle load strobe; sampled each cycle.
- o_Busy  out  1  conversion in progress.
- o_Overflow  out  1  displayed value saturated.
- o_Segments  out  7  segment pattern, active-high, bit0=a … bit6=g.
- o_DigitSelect  out  NUM_DIGITS  one-hot active-high digit enable, bit0 = least-significant digit.

Behaviour:
- Reset values:
  - o_Busy=0, o_Overflow=0.
  - Displayed BCD register = all zeros.
  - Digit index=0, refresh counter=0.
  - o_DigitSelect=1 (digit 0).
  - o_Segments=7'b0111111 (glyph "0").
  - Pending flag=0.
- Reset mid-conversion aborts the conversion and clears the pending score; the display returns to zeros.
- Conversion FSM states: IDLE, SHIFT, DONE.
  - IDLE + i_ScoreValid → latch i_Score.
    - Set overflow_next = (i_Score > 10^NUM_DIGITS − 1).
    - Clear the shift counter and go to SHIFT; o_Busy=1 next cycle.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift left one bit, taking the binary MSB. After SCORE_WIDTH shifts go to DONE.
  - DONE: the displayed register loads the converted BCD, or all nibbles = 9 if overflow_next.
    - o_Overflow takes overflow_next in the same cycle.
    - o_Busy=0 next cycle.
    - Go to IDLE, or straight to SHIFT if pending is set.
- Latency: strobe at cycle N → new value visible on displayed register at cycle N+SCORE_WIDTH+2. The display never shows a partial conversion; it updates atomically.
- i_ScoreValid while busy (SHIFT or DONE):
  - The score is stored in a one-deep pending register and pending=1.
  - Later strobes overwrite it; last wins.
  - Pending starts a conversion from DONE without an IDLE cycle and clears pending.
- Internal BCD working width is sized to hold 2^SCORE_WIDTH−1. Only the low NUM_DIGITS nibbles are displayed.
- Refresh:
  - The counter runs 0..REFRESH_DIV−1 continuously, independent of the FSM.
  - On wrap, digit index increments modulo NUM_DIGITS (NUM_DIGITS−1 → 0).
  - o_DigitSelect and o_Segments are registered. Both change on the same edge, one cycle after the index changes, so they are always coherent.
- Segment decode: 0–9 use the standard glyphs. Nibble values 10–15 cannot occur; decode them to blank (7'b0).

Optional Feature:
- Macro SNAKE_SCOREBOARD_BLANK_ZEROS_EN.
- Defined: leading-zero blanking. Any digit above the most significant nonzero digit shows 7'b0000000. Digit 0 always shows, so score 0 displays "0".
  - The blank mask is computed once in DONE alongside the display load.
  - o_DigitSelect still cycles through all digits.
- Undefined: all digits always shown, including leading zeros.

Decomposition:
- Shared package/include snake_display_pkg holds:
  - The seven-segment glyph constants for 0–9 and blank.
  - The FSM state encodings (IDLE/SHIFT/DONE).
  - A constant function for the BCD digit count of a given binary width.
- Natural sub-module: snake_bin2bcd, the sequential double-dabble engine with start/busy/done and pending handling. The top keeps the refresh divider, digit mux, decode and blanking.

Test Plan:
- Reset check: assert i_Reset 3 cycles → o_DigitSelect=4'b0001, o_Segments=7'b0111111, o_Busy=0, o_Overflow=0.
- Conversion latency: strobe i_Score=1234 → o_Busy high for SCORE_WIDTH+1 cycles; displayed digits 4,3,2,1 on digit0..3 exactly 16 cycles after the strobe.
- Refresh walk (REFRESH_DIV=4): o_DigitSelect goes 0001→0010→0100→1000→0001 every 4 cycles; o_Segments matches the selected digit on every edge.
- Overflow (NUM_DIGITS=4): i_Score=10000 → all digits show 9, o_Overflow=1. A subsequent i_Score=42 clears o_Overflow and shows 0042.
- Back-to-back loads: strobe 17, then 250 and 999 during busy → display shows 17, then 999 with no IDLE gap; 250 is never displayed.
- Reset and blanking: i_Reset mid-SHIFT → zeros, pending dropped. With SNAKE_SCOREBOARD_BLANK_ZEROS_EN, score 7 → digits 1–3 blank and digit 0 = "7"; score 0 → only digit 0 shows "0".

Source files
------------

// File: rtl/snake_display_pkg.sv
// Shared definitions for the snake scoreboard: seven-segment glyphs,
// converter FSM state encoding and constant sizing helpers.
package snake_display_pkg;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_e;

    // Decimal digits needed to hold 2^width - 1.
    function automatic int bcd_digits(input int width);
        logic [63:0] v;
        int          n;
        v = (64'd1 << width) - 64'd1;
        n = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            n++;
        end
        return n;
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/snake_scoreboard_mux_bin2bcd.sv
// Sequential double-dabble converter (module snake_bin2bcd) with a one-deep,
// last-wins pending slot for scores that arrive while a conversion runs.
module snake_bin2bcd
    import snake_display_pkg::*;
#(
    parameter int SCORE_WIDTH = 14,
    parameter int NUM_DIGITS  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [SCORE_WIDTH-1:0]  score,
    output conv_state_e             state_o,
    output logic                    overflow_o,
    output logic [4*NUM_DIGITS-1:0] bcd_o
);

    localparam int          BCD_DIGITS = bcd_digits(SCORE_WIDTH);
    localparam int          BCD_W      = 4 * BCD_DIGITS;
    localparam int          CNT_W      = $clog2(SCORE_WIDTH + 1);
    localparam logic [63:0] MAX_DISP   = pow10(NUM_DIGITS) - 64'd1;

    conv_state_e             state_q, state_d;
    logic [SCORE_WIDTH-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]        bcd_q, bcd_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    pend_q, pend_d;
    logic [SCORE_WIDTH-1:0]  pend_score_q, pend_score_d;
    logic                    ovf_q, ovf_d;
    logic [BCD_W+SCORE_WIDTH-1:0] shifted;

    function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic too_big(input logic [SCORE_WIDTH-1:0] s);
        return 64'(s) > MAX_DISP;
    endfunction

    always_comb begin
        state_d      = state_q;
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        pend_score_d = pend_score_q;
        ovf_d        = ovf_q;
        shifted      = {dabble(bcd_q), bin_q} << 1;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bin_d   = score;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = too_big(score);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bcd_d = shifted[BCD_W+SCORE_WIDTH-1:SCORE_WIDTH];
                bin_d = shifted[SCORE_WIDTH-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(SCORE_WIDTH - 1)) state_d = ST_DONE;
                if (start) begin
                    pend_d       = 1'b1;
                    pend_score_d = score;
                end
            end
            ST_DONE: begin
                // A queued score restarts immediately; a strobe in this same
                // cycle becomes the next pending entry.
                if (pend_q) begin
                    bin_d   = pend_score_q;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = too_big(pend_score_q);
                    pend_d  = 1'b0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
                if (start) begin
                    pend_d       = 1'b1;
                    pend_score_d = score;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bin_q        <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            pend_score_q <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            pend_score_q <= pend_score_d;
            ovf_q        <= ovf_d;
        end
    end

    always_comb begin
        bcd_o = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i < BCD_DIGITS) bcd_o[4*i +: 4] = bcd_q[4*((i < BCD_DIGITS) ? i : 0) +: 4];
        end
    end

    assign state_o    = state_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/snake_scoreboard_mux.sv
// Scoreboard driver: BCD conversion, refresh divider and multiplexed 7-seg output.
// Optional leading-zero blanking via `define SNAKE_SCOREBOARD_BLANK_ZEROS_EN.
module snake_scoreboard_mux
    import snake_display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SCORE_WIDTH = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic [SCORE_WIDTH-1:0] i_Score,
    input  logic                   i_ScoreValid,
    output logic                   o_Busy,
    output logic                   o_Overflow,
    output logic [6:0]             o_Segments,
    output logic [NUM_DIGITS-1:0]  o_DigitSelect
);

    localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DISP_W = 4 * NUM_DIGITS;

    conv_state_e          conv_state;
    logic                 conv_done;
    logic                 conv_ovf;
    logic [DISP_W-1:0]    conv_bcd;

    logic [REF_W-1:0]      ref_cnt_q, ref_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DISP_W-1:0]     disp_q, disp_d;
    logic                  ovf_q, ovf_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic [NUM_DIGITS-1:0] blank_mask;
    logic [3:0]            cur_nib;
    logic                  cur_blank;

    snake_bin2bcd #(
        .SCORE_WIDTH (SCORE_WIDTH),
        .NUM_DIGITS  (NUM_DIGITS)
    ) u_bin2bcd (
        .clk        (i_Clk),
        .rst        (i_Reset),
        .start      (i_ScoreValid),
        .score      (i_Score),
        .state_o    (conv_state),
        .overflow_o (conv_ovf),
        .bcd_o      (conv_bcd)
    );

    assign conv_done = (conv_state == ST_DONE);
    assign o_Busy    = (conv_state != ST_IDLE);

    always_comb begin
        ref_cnt_d = ref_cnt_q + 1'b1;
        idx_d     = idx_q;
        if (ref_cnt_q == REF_W'(REFRESH_DIV - 1)) begin
            ref_cnt_d = '0;
            idx_d     = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // The display only ever changes in DONE, so it never shows a partial value.
    always_comb begin
        disp_d = disp_q;
        ovf_d  = ovf_q;
        if (conv_done) begin
            disp_d = conv_ovf ? {NUM_DIGITS{4'h9}} : conv_bcd;
            ovf_d  = conv_ovf;
        end
    end

`ifdef SNAKE_SCOREBOARD_BLANK_ZEROS_EN
    logic [NUM_DIGITS-1:0] blank_q, blank_d;
    logic                  seen_nonzero;

    always_comb begin
        blank_d      = blank_q;
        seen_nonzero = 1'b0;
        if (conv_done) begin
            for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
                seen_nonzero = seen_nonzero | (disp_d[4*i +: 4] != 4'd0);
                blank_d[i]   = ~seen_nonzero;
            end
            blank_d[0] = 1'b0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            blank_q    <= '1;
            blank_q[0] <= 1'b0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank_mask = blank_q;
`else
    assign blank_mask = '0;
`endif

    always_comb begin
        cur_nib   = 4'd0;
        cur_blank = 1'b0;
        sel_d     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            sel_d[i] = (idx_q == IDX_W'(i));
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = disp_q[4*i +: 4];
                cur_blank = blank_mask[i];
            end
        end
        seg_d = cur_blank ? SEG_BLANK : seg_decode(cur_nib);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            ref_cnt_q <= '0;
            idx_q     <= '0;
            disp_q    <= '0;
            ovf_q     <= 1'b0;
            seg_q     <= SEG_0;
            sel_q     <= '0;
            sel_q[0]  <= 1'b1;
        end else begin
            ref_cnt_q <= ref_cnt_d;
            idx_q     <= idx_d;
            disp_q    <= disp_d;
            ovf_q     <= ovf_d;
            seg_q     <= seg_d;
            sel_q     <= sel_d;
        end
    end

    assign o_Overflow    = ovf_q;
    assign o_Segments    = seg_q;
    assign o_DigitSelect = sel_q;

endmodule

// File: tb/tb_snake_scoreboard_mux.sv
// Testbench for snake_scoreboard_mux: directed loads with a scoreboard queue
// of expected display frames, checked by an independent monitor.
module tb_snake_scoreboard_mux;

    localparam int NUM_DIGITS  = 4;
    localparam int SCORE_WIDTH = 14;
    localparam int REFRESH_DIV = 4;
    localparam int FRAME_W     = 7 * NUM_DIGITS + 1;

    // Index 10 is the blank glyph.
    localparam logic [6:0] GLYPH [0:10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h00};

    logic                   i_Clk;
    logic                   i_Reset;
    logic [SCORE_WIDTH-1:0] i_Score;
    logic                   i_ScoreValid;
    logic                   o_Busy;
    logic                   o_Overflow;
    logic [6:0]             o_Segments;
    logic [NUM_DIGITS-1:0]  o_DigitSelect;

    int tests_run;
    int tests_failed;
    logic [FRAME_W-1:0] exp_q[$];

    snake_scoreboard_mux #(
        .NUM_DIGITS  (NUM_DIGITS),
        .SCORE_WIDTH (SCORE_WIDTH),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .i_Clk         (i_Clk),
        .i_Reset       (i_Reset),
        .i_Score       (i_Score),
        .i_ScoreValid  (i_ScoreValid),
        .o_Busy        (o_Busy),
        .o_Overflow    (o_Overflow),
        .o_Segments    (o_Segments),
        .o_DigitSelect (o_DigitSelect)
    );

    // Clock and watchdog.
    initial begin
        i_Clk = 1'b0;
        forever #5 i_Clk = ~i_Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame layout: bit 28 = overflow, digit i glyph in bits [7*i +: 7].
    function automatic logic [FRAME_W-1:0] make_frame(input int d3, input int d2,
                                                      input int d1, input int d0,
                                                      input logic ovf);
        int d[4];
        logic [FRAME_W-1:0] f;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
`ifdef SNAKE_SCOREBOARD_BLANK_ZEROS_EN
        for (int i = 3; i >= 1; i--) begin
            if (d[i] != 0) break;
            d[i] = 10;
        end
`endif
        f = '0;
        for (int i = 0; i < 4; i++) f[7*i +: 7] = GLYPH[d[i]];
        f[FRAME_W-1] = ovf;
        return f;
    endfunction

    function automatic int sel_index(input logic [NUM_DIGITS-1:0] sel);
        int idx;
        idx = -1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel == NUM_DIGITS'(1 << i)) idx = i;
        end
        return idx;
    endfunction

    // Driver tasks; all are entered and left on a falling edge.
    task automatic load(input logic [SCORE_WIDTH-1:0] s);
        i_Score      = s;
        i_ScoreValid = 1'b1;
        @(negedge i_Clk);
        i_ScoreValid = 1'b0;
    endtask

    task automatic busy_run(output int n);
        n = 0;
        while (o_Busy && n < 200) begin
            n++;
            @(negedge i_Clk);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (o_Busy && t < 200) begin
            t++;
            @(negedge i_Clk);
        end
        check("idle_reached", 32'(o_Busy), 32'd0);
        repeat (NUM_DIGITS * REFRESH_DIV + 4) @(negedge i_Clk);
    endtask

    task automatic reset_and_walk(input int cycles);
        int         exp_idx;
        logic [6:0] exp_seg;
        i_Reset = 1'b1;
        repeat (cycles) @(negedge i_Clk);
        check("reset_sel", 32'(o_DigitSelect), 32'h1);
        check("reset_seg", 32'(o_Segments), 32'h3F);
        check("reset_busy", 32'(o_Busy), 32'd0);
        check("reset_ovf", 32'(o_Overflow), 32'd0);
        i_Reset = 1'b0;
        for (int k = 1; k <= 5 * REFRESH_DIV; k++) begin
            @(negedge i_Clk);
            exp_idx = ((k - 1) / REFRESH_DIV) % NUM_DIGITS;
            exp_seg = GLYPH[0];
`ifdef SNAKE_SCOREBOARD_BLANK_ZEROS_EN
            if (exp_idx != 0) exp_seg = GLYPH[10];
`endif
            check("walk_sel", 32'(o_DigitSelect), 32'(1 << exp_idx));
            check("walk_seg", 32'(o_Segments), 32'(exp_seg));
        end
    endtask

    // Monitor: pops one expected frame per completed conversion, then checks
    // every coherent digit/segment pair and the overflow flag until the next one.
    initial begin : monitor
        logic [FRAME_W-1:0] cur;
        bit                 have;
        int                 age;
        int                 d;
        have = 1'b0;
        age  = 0;
        cur  = '0;
        forever begin
            @(negedge i_Clk);
            if (i_Reset) begin
                have = 1'b0;
                continue;
            end
            if (have) begin
                age++;
                if (age >= 2) begin
                    d = sel_index(o_DigitSelect);
                    if (d < 0) begin
                        check("sel_onehot", 32'(o_DigitSelect), 32'd1);
                    end else begin
                        check("frame_seg", 32'(o_Segments), 32'(cur[7*d +: 7]));
                    end
                    check("frame_ovf", 32'(o_Overflow), 32'(cur[FRAME_W-1]));
                end
            end
            if (dut.conv_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                    have = 1'b0;
                end else begin
                    cur  = exp_q.pop_front();
                    have = 1'b1;
                    age  = 0;
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        tests_run    = 0;
        tests_failed = 0;
        i_Reset      = 1'b1;
        i_ScoreValid = 1'b0;
        i_Score      = '0;

        reset_and_walk(3);

        exp_q.push_back(make_frame(1, 2, 3, 4, 1'b0));
        load(14'd1234);
        busy_run(n);
        check("busy_len_1234", 32'(n), 32'd15);
        wait_idle();

        exp_q.push_back(make_frame(9, 9, 9, 9, 1'b1));
        load(14'd10000);
        wait_idle();

        exp_q.push_back(make_frame(0, 0, 4, 2, 1'b0));
        load(14'd42);
        wait_idle();

        // 250 is overwritten by 999 in the pending slot and never shown.
        exp_q.push_back(make_frame(0, 0, 1, 7, 1'b0));
        exp_q.push_back(make_frame(0, 9, 9, 9, 1'b0));
        load(14'd17);
        fork
            busy_run(n);
            begin
                repeat (2) @(negedge i_Clk);
                load(14'd250);
                load(14'd999);
            end
        join
        check("busy_len_b2b", 32'(n), 32'd30);
        wait_idle();

        exp_q.push_back(make_frame(9, 9, 9, 9, 1'b1));
        load(14'd16383);
        wait_idle();

        // Reset in mid-conversion with a pending score queued behind it.
        load(14'd5678);
        repeat (3) @(negedge i_Clk);
        load(14'd3333);
        repeat (2) @(negedge i_Clk);
        reset_and_walk(1);

        exp_q.push_back(make_frame(0, 0, 0, 7, 1'b0));
        load(14'd7);
        wait_idle();

        exp_q.push_back(make_frame(0, 0, 0, 0, 1'b0));
        load(14'd0);
        wait_idle();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
